vga_arbiter: RTL
================

VGA_ARBITER -- requirements
Module: vga_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters; requester 0 is draw_grid, 1 is draw_player, 2 is the renderer.
REQ-002 Parameter PACE, default 16'd4: minimum clock cycles between accepted pixels when pacing is compiled in; 0 and 1 both mean one pixel per cycle.
REQ-003 Port clock, input, 1: single system clock; all logic is rising-edge.
REQ-004 Port resetn, input, 1: asynchronous, active-low reset.
REQ-005 Port req, input, N_REQ: requester i wants ownership of the VGA write port.
REQ-006 Port gnt, output, N_REQ: one-hot or zero; requester i owns the port.
REQ-007 Port req_x / req_y / req_colour, inputs, 8*N_REQ / 7*N_REQ / 3*N_REQ: packed per-requester pixel fields; slice i belongs to requester i.
REQ-008 Port req_write, input, N_REQ: requester i presents a pixel.
REQ-009 Port req_ready, output, N_REQ: pixel from requester i is accepted this cycle.
REQ-010 Port vga_x / vga_y / vga_colour / vga_write, outputs, 8 / 7 / 3 / 1: registered VGA adapter write port.
REQ-011 Port busy, output, 1: high in every state except IDLE.

Function
REQ-012 FSM states: IDLE, ARB, OWN, RELEASE.
REQ-013 IDLE: go to ARB when any req bit is high; otherwise stay in IDLE.
REQ-014 ARB: one cycle; latch the winner into gnt, then go to OWN.
REQ-015 ARB priority is round-robin: search starts at rr_ptr and wraps modulo N_REQ; the first requester with req high wins.
REQ-016 If req is all-zero in ARB, go to IDLE with gnt=0.
REQ-017 OWN: gnt is held while req of the owner stays high (burst lock); no preemption.
REQ-018 OWN: the cycle the owner's req is sampled low, go to RELEASE.
REQ-019 RELEASE: gnt=0, rr_ptr <= (owner+1) mod N_REQ, then go to IDLE.
REQ-020 req_ready[i] = (state==OWN) & gnt[i] & req[i] & pace_zero; it is combinational.
REQ-021 A pixel is accepted when req_ready[i] & req_write[i] are both high.
REQ-022 On acceptance, on the next edge: vga_x/y/colour <= slice i and vga_write <= 1 (latency 1 cycle).
REQ-023 vga_write is otherwise 0.
REQ-024 vga_x/y/colour hold their last value when vga_write is 0.
REQ-025 A write asserted with req low, or by a non-owner, is ignored; no output change.
REQ-026 Pace counter: 16-bit, loaded with PACE-1 on acceptance (0 if PACE<=1), decrements to 0 and saturates there.
REQ-027 The pace counter keeps running across grant changes.
REQ-028 pace_zero = counter==0.
REQ-029 Minimum handover gap between owners is 3 cycles (RELEASE, IDLE, ARB).

Reset
REQ-030 On resetn low, immediately: state=IDLE, gnt=0, rr_ptr=0, pace counter=0, vga_x=0, vga_y=0, vga_colour=0, vga_write=0, busy=0.
REQ-031 Reset mid-burst drops the grant and any pixel in flight; no write is emitted after reset deasserts until a new ARB/OWN cycle.

Configuration
REQ-032 Macro VGA_ARB_PACE_EN defined: pace counter present, behaviour per REQ-026 to REQ-028.
REQ-033 Macro VGA_ARB_PACE_EN undefined: no counter, pace_zero is constant 1, PACE is ignored, and a pixel may be accepted every cycle in OWN.

Structure
REQ-034 Package vga_pkg holds VGA_X_W=8, VGA_Y_W=7, VGA_C_W=3, the arbiter state enum, and the requester index constants REQ_GRID=0, REQ_PLAYER=1, REQ_RENDER=2.
REQ-035 One sub-module, vga_pace_timer (load, count, zero flag), instantiated only under VGA_ARB_PACE_EN.

Verification
REQ-036 Single requester: req=3'b001, req_write held 1 for 10 cycles, PACE=4 -> gnt=3'b001 after 2 cycles; vga_write pulses every 4 cycles carrying req0 x/y/colour one cycle after acceptance.
REQ-037 Contention/fairness: req=3'b111 held for three bursts, each owner dropping req after 2 pixels -> grant order 0,1,2 and no owner re-granted while others wait.
REQ-038 Burst lock: owner 1 active, req0 raised mid-burst -> gnt stays 3'b010 until req1 drops; after RELEASE, IDLE, ARB, gnt=3'b001.
REQ-039 Illegal write: req_write[2]=1 with gnt=3'b001 -> req_ready[2]=0 and no vga_write.
REQ-040 Reset mid-burst: resetn low during OWN with an accepted pixel pending -> all outputs 0 immediately; no vga_write pulse after release.
REQ-041 Macro off: VGA_ARB_PACE_EN undefined, continuous writes -> vga_write high every cycle during OWN.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared widths, requester indices and arbiter state encoding for the VGA write-port arbiter
package vga_pkg;
  localparam int VGA_X_W = 8;
  localparam int VGA_Y_W = 7;
  localparam int VGA_C_W = 3;
  localparam int REQ_GRID = 0;
  localparam int REQ_PLAYER = 1;
  localparam int REQ_RENDER = 2;
  typedef enum logic [1:0] {IDLE, ARB, OWN, RELEASE} arb_state_e;
endpackage

// File: rtl/vga_pace_timer.sv
// vga_pace_timer: saturating down-counter that spaces accepted pixels; zero flag means a pixel may be taken
module vga_pace_timer #(
  parameter logic [15:0] LOAD_VAL = 16'd3
) (
  input  logic clock,
  input  logic resetn,
  input  logic load,
  output logic zero
);
  logic [15:0] cnt_q, cnt_d;
  // reload on every accepted pixel, otherwise count down and stick at zero
  always_comb cnt_d = load ? LOAD_VAL : (cnt_q == 16'd0 ? 16'd0 : cnt_q - 16'd1);
  // counter register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign zero = cnt_q == 16'd0;
endmodule

// File: rtl/vga_arbiter.sv
// vga_arbiter: round-robin, burst-locked owner of the VGA adapter write port (pixel pacing under VGA_ARB_PACE_EN)
module vga_arbiter
  import vga_pkg::*;
#(
  parameter int          N_REQ = 3,
  parameter logic [15:0] PACE  = 16'd4
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [N_REQ-1:0]           req,
  output logic [N_REQ-1:0]           gnt,
  input  logic [VGA_X_W*N_REQ-1:0]   req_x,
  input  logic [VGA_Y_W*N_REQ-1:0]   req_y,
  input  logic [VGA_C_W*N_REQ-1:0]   req_colour,
  input  logic [N_REQ-1:0]           req_write,
  output logic [N_REQ-1:0]           req_ready,
  output logic [VGA_X_W-1:0]         vga_x,
  output logic [VGA_Y_W-1:0]         vga_y,
  output logic [VGA_C_W-1:0]         vga_colour,
  output logic                       vga_write,
  output logic                       busy
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  arb_state_e state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [IW-1:0] rr_q, own_q, own_nx, win, idx;
  logic found, acc, pace_zero;
  logic [VGA_X_W-1:0] vga_x_q;
  logic [VGA_Y_W-1:0] vga_y_q;
  logic [VGA_C_W-1:0] vga_colour_q;
  logic vga_write_q;
  // round-robin search: first requester at or after rr_q, wrapping modulo N_REQ
  always_comb begin
    win = rr_q;
    idx = rr_q;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(rr_q) + k) % N_REQ);
      if (!found && req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign own_nx = own_q == IW'(N_REQ - 1) ? '0 : own_q + 1'b1;
  assign req_ready = (state_q == OWN && pace_zero) ? (gnt_q & req) : '0;
  assign acc = |(req_ready & req_write);
  // arbitration FSM: grant is latched in ARB and held until the owner lets go of req
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      gnt_q <= '0;
      rr_q <= '0;
      own_q <= '0;
    end else begin
      case (state_q)
        IDLE: state_q <= |req ? ARB : IDLE;
        ARB: begin
          gnt_q <= found ? N_REQ'(1) << win : '0;
          own_q <= win;
          state_q <= found ? OWN : IDLE;
        end
        OWN: if (!req[own_q]) begin
          gnt_q <= '0;
          state_q <= RELEASE;
        end
        RELEASE: begin
          rr_q <= own_nx;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // registered VGA port: capture the owner's pixel one cycle after acceptance, hold otherwise
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vga_x_q <= '0;
      vga_y_q <= '0;
      vga_colour_q <= '0;
      vga_write_q <= 1'b0;
    end else begin
      vga_write_q <= acc;
      if (acc) begin
        vga_x_q <= req_x[own_q*VGA_X_W +: VGA_X_W];
        vga_y_q <= req_y[own_q*VGA_Y_W +: VGA_Y_W];
        vga_colour_q <= req_colour[own_q*VGA_C_W +: VGA_C_W];
      end
    end
  end
`ifdef VGA_ARB_PACE_EN
  localparam logic [15:0] PACE_LD = PACE <= 16'd1 ? 16'd0 : PACE - 16'd1;
  vga_pace_timer #(.LOAD_VAL(PACE_LD)) u_pace (
    .clock (clock),
    .resetn(resetn),
    .load  (acc),
    .zero  (pace_zero)
  );
`else
  assign pace_zero = 1'b1;
`endif
  assign gnt = gnt_q;
  assign vga_x = vga_x_q;
  assign vga_y = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_write = vga_write_q;
  assign busy = state_q != IDLE;
endmodule
